// File: rtl/rr_mux_n.sv
// N-channel registered multiplexer with valid/ready handshake and round-robin arbitration.
// Define RR_MUX_FIXED_PRIO_EN to replace round-robin with fixed lowest-index-wins priority.
module rr_mux_n #(
    parameter  int N_CH   = 4,
    parameter  int DATA_W = 8,
    localparam int SEL_W  = $clog2(N_CH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_CH*DATA_W-1:0]   in_data,
    input  logic [N_CH-1:0]          in_valid,
    output logic [N_CH-1:0]          in_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic [SEL_W-1:0]         out_ch,
    output logic                     out_valid,
    input  logic                     out_ready
);

    logic [DATA_W-1:0] ch_data [N_CH];

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_unpack
            assign ch_data[gi] = in_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [SEL_W-1:0]  out_ch_q, out_ch_d;
    logic              out_valid_q, out_valid_d;

    logic              load;
    logic              any_valid;
    logic [SEL_W-1:0]  grant_idx;
    logic [N_CH-1:0]   grant;

    assign load = !out_valid_q || out_ready;

`ifdef RR_MUX_FIXED_PRIO_EN
    // Descending scan so the lowest valid index is the last (winning) assignment.
    always_comb begin
        any_valid = 1'b0;
        grant_idx = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (in_valid[i]) begin
                any_valid = 1'b1;
                grant_idx = SEL_W'(i);
            end
        end
    end
`else
    localparam logic [SEL_W:0] N_CH_W = (SEL_W + 1)'(N_CH);

    logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [SEL_W:0]   scan_sum;
    logic [SEL_W-1:0] scan_idx;

    // Scan starts at rr_ptr and wraps modulo N_CH; the first valid channel wins.
    always_comb begin
        any_valid = 1'b0;
        grant_idx = '0;
        scan_sum  = '0;
        scan_idx  = '0;
        for (int k = 0; k < N_CH; k++) begin
            scan_sum = {1'b0, rr_ptr_q} + (SEL_W + 1)'(k);
            if (scan_sum >= N_CH_W) begin
                scan_sum = scan_sum - N_CH_W;
            end
            scan_idx = scan_sum[SEL_W-1:0];
            if (!any_valid && in_valid[scan_idx]) begin
                any_valid = 1'b1;
                grant_idx = scan_idx;
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (load && any_valid) begin
            if (grant_idx == SEL_W'(N_CH - 1)) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = grant_idx + SEL_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`endif

    always_comb begin
        grant = '0;
        if (any_valid) begin
            grant[grant_idx] = 1'b1;
        end
    end

    // Reset gating keeps producers from seeing a grant while the stage is held in reset.
    assign in_ready = {N_CH{load && rst_n}} & grant;

    always_comb begin
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_valid_d = out_valid_q;
        if (load) begin
            out_valid_d = any_valid;
            if (any_valid) begin
                out_data_d = ch_data[grant_idx];
                out_ch_d   = grant_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_rr_mux_n.sv
// Vector-table bench for rr_mux_n (N_CH=4, DATA_W=8) with a scoreboard of granted words.
module tb_rr_mux_n;

    localparam int N_CH   = 4;
    localparam int DATA_W = 8;
    localparam int SEL_W  = 2;

    logic                   clk;
    logic                   rst_n;
    logic [N_CH*DATA_W-1:0] in_data;
    logic [N_CH-1:0]        in_valid;
    logic [N_CH-1:0]        in_ready;
    logic [DATA_W-1:0]      out_data;
    logic [SEL_W-1:0]       out_ch;
    logic                   out_valid;
    logic                   out_ready;

    rr_mux_n #(.N_CH(N_CH), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic [3:0]  iv;
        logic        ordy;
        logic [31:0] din;
        logic [3:0]  rdy;   // expected in_ready during this cycle
        logic        ov;    // expected out_valid after this cycle's edge
    } vec_t;

    typedef struct {
        logic [SEL_W-1:0]  ch;
        logic [DATA_W-1:0] data;
    } word_t;

    vec_t  vecs[$];
    word_t sb[$];
    word_t exp_word;
    int    checks   = 0;
    int    failures = 0;

    task automatic check(input string name, input int row, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s row=%0d got=%h exp=%h", name, row, got, exp);
        end
    endtask

    initial begin
        logic [31:0] d_a;
        logic [31:0] d_5c;
        d_a  = 32'hA3A2A1A0;
        d_5c = 32'hA35CA1A0;

        // Reset with every channel requesting
        vecs.push_back('{1'b0, 4'hF, 1'b1, d_a, 4'h0, 1'b0});
        vecs.push_back('{1'b0, 4'hF, 1'b1, d_a, 4'h0, 1'b0});
`ifdef RR_MUX_FIXED_PRIO_EN
        for (int i = 0; i < 4; i++) vecs.push_back('{1'b1, 4'hF, 1'b1, d_a, 4'b0001, 1'b1});
        vecs.push_back('{1'b1, 4'hE, 1'b1, d_a, 4'b0010, 1'b1});
        vecs.push_back('{1'b1, 4'hE, 1'b1, d_a, 4'b0010, 1'b1});
        vecs.push_back('{1'b1, 4'h8, 1'b0, d_a, 4'b0000, 1'b1});
        vecs.push_back('{1'b1, 4'hC, 1'b1, d_a, 4'b0100, 1'b1});
        vecs.push_back('{1'b1, 4'h0, 1'b1, d_a, 4'b0000, 1'b0});
`else
        // Rotation: 0,1,2,3,0,1,2,3
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 4; c++) vecs.push_back('{1'b1, 4'hF, 1'b1, d_a, 4'(1 << c), 1'b1});
        end
        // Steer rr_ptr to 3, then skip/wrap with ch1 and ch3 valid
        vecs.push_back('{1'b1, 4'b0100, 1'b1, d_a, 4'b0100, 1'b1});
        vecs.push_back('{1'b1, 4'b1010, 1'b1, d_a, 4'b1000, 1'b1});
        vecs.push_back('{1'b1, 4'b1010, 1'b1, d_a, 4'b0010, 1'b1});
        vecs.push_back('{1'b1, 4'b1010, 1'b1, d_a, 4'b1000, 1'b1});
        // Back-pressure holding A2 for three cycles, then drain+fill from ch0
        vecs.push_back('{1'b1, 4'b0100, 1'b1, d_a, 4'b0100, 1'b1});
        for (int s = 0; s < 3; s++) vecs.push_back('{1'b1, 4'b0001, 1'b0, d_a, 4'b0000, 1'b1});
        vecs.push_back('{1'b1, 4'b0001, 1'b1, d_a, 4'b0001, 1'b1});
        // Idle drain of a single 5C word on ch2
        vecs.push_back('{1'b1, 4'b0100, 1'b1, d_5c, 4'b0100, 1'b1});
        vecs.push_back('{1'b1, 4'b0000, 1'b1, d_5c, 4'b0000, 1'b0});
        vecs.push_back('{1'b1, 4'b0000, 1'b1, d_5c, 4'b0000, 1'b0});
        // Reset while a word is held, then resume from rr_ptr=0
        vecs.push_back('{1'b1, 4'hF, 1'b1, d_a, 4'b1000, 1'b1});
        vecs.push_back('{1'b0, 4'hF, 1'b0, d_a, 4'b0000, 1'b0});
        vecs.push_back('{1'b1, 4'b1000, 1'b1, d_a, 4'b1000, 1'b1});
`endif

        rst_n     = 1'b0;
        in_valid  = '0;
        in_data   = '0;
        out_ready = 1'b0;
        exp_word  = '{ch: '0, data: '0};

        for (int r = 0; r < vecs.size(); r++) begin
            @(negedge clk);
            rst_n     = vecs[r].rst_n;
            in_valid  = vecs[r].iv;
            out_ready = vecs[r].ordy;
            in_data   = vecs[r].din;
            #1;
            check("in_ready", r, 32'(in_ready), 32'(vecs[r].rdy));
            for (int c = 0; c < N_CH; c++) begin
                if (vecs[r].rdy[c]) sb.push_back('{ch: SEL_W'(c), data: vecs[r].din[c*DATA_W +: DATA_W]});
            end
            @(posedge clk);
            #1;
            if (!vecs[r].rst_n) begin
                sb.delete();
                exp_word = '{ch: '0, data: '0};
            end else if (sb.size() > 0) begin
                exp_word = sb.pop_front();
            end
            $display("row %0d: rst_n=%b iv=%b ordy=%b rdy=%b -> ov=%b ch=%0d data=%h",
                     r, vecs[r].rst_n, vecs[r].iv, vecs[r].ordy, in_ready, out_valid, out_ch, out_data);
            check("out_valid", r, 32'(out_valid), 32'(vecs[r].ov));
            check("out_ch", r, 32'(out_ch), 32'(exp_word.ch));
            check("out_data", r, 32'(out_data), 32'(exp_word.data));
        end

        // Lone request on ch1: must be granted and appear within a bounded number of cycles
        begin
            int  waited;
            bit  seen;
            @(negedge clk);
            in_valid  = 4'b0010;
            out_ready = 1'b1;
            in_data   = 32'hA3A2A1A0;
            #1;
            check("lone_ready", 100, 32'(in_ready), 32'h2);
            seen   = 1'b0;
            waited = 0;
            while (!seen && waited < 4) begin
                @(posedge clk);
                #1;
                waited++;
                if (out_valid && out_ch == SEL_W'(1)) seen = 1'b1;
            end
            check("lone_seen", 100, 32'(seen), 32'h1);
            check("lone_data", 100, 32'(out_data), 32'hA1);
            $display("seq lone ch1: waited=%0d ov=%b ch=%0d data=%h", waited, out_valid, out_ch, out_data);

            // Withdraw the request under stall: word must hold, no grant offered
            @(negedge clk);
            in_valid  = 4'b0000;
            out_ready = 1'b0;
            #1;
            check("stall_ready", 101, 32'(in_ready), 32'h0);
            @(posedge clk);
            #1;
            check("stall_valid", 101, 32'(out_valid), 32'h1);
            check("stall_data", 101, 32'(out_data), 32'hA1);
            $display("seq stall: ov=%b ch=%0d data=%h", out_valid, out_ch, out_data);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rr_mux_n.md
Name: rr_mux_n

Overview:
- Parametrised N-channel, W-bit registered multiplexer with per-channel valid/ready handshake and round-robin arbitration.
- Replaces the fixed 4:1 combinational select with an arbitrated, back-pressure-aware stage.
- Sits between several producers and one consumer; also reports which channel each output word came from.

Parameters:
- N_CH, 4, number of input channels (2..16).
- DATA_W, 8, data width per channel.
- SEL_W, $clog2(N_CH), width of channel index. Derived localparam; not to be overridden.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
- in_data  input  N_CH*DATA_W  packed channel data; channel i at bits [i*DATA_W +: DATA_W].
- in_valid  input  N_CH  channel i has a word.
- in_ready  output  N_CH  channel i word is accepted this cycle.
- out_data  output  DATA_W  registered selected word.
- out_ch  output  SEL_W  index of the channel that supplied out_data.
- out_valid  output  1  out_data/out_ch hold a word.
- out_ready  input  1  consumer accepts the word this cycle.

Behaviour:
- Reset (rst_n=0 at posedge): out_valid=0, out_data=0, out_ch=0, rr_ptr=0. in_ready is combinational and is all-zero while rst_n=0.
- load = !out_valid || out_ready. The output register can take a new word this cycle.
- Arbitration (combinational):
  - Scan channels rr_ptr, rr_ptr+1, ..., wrapping modulo N_CH.
  - The first channel with in_valid=1 is granted (one-hot grant, at most one bit set).
- in_ready[i] = load && grant[i]. An input transfer occurs when in_valid[i] && in_ready[i].
- On a transfer at posedge:
  - out_data <= in_data[g]; out_ch <= g; out_valid <= 1.
  - rr_ptr <= (g+1) mod N_CH. Wrap from N_CH-1 to 0.
- When load=1 and no channel is valid: out_valid <= 0 at posedge. out_data and out_ch hold their old values; rr_ptr is unchanged.
- Stall (out_valid=1, out_ready=0):
  - out_data, out_ch and out_valid hold.
  - All in_ready=0; rr_ptr holds.
- Simultaneous drain and fill (out_valid=1, out_ready=1, some in_valid=1): new word loaded in the same cycle. This gives full throughput of one word per cycle.
- Latency: exactly 1 cycle from input transfer to out_valid.
- Fairness: with all channels continuously valid and out_ready=1, grants rotate 0,1,2,...,N_CH-1,0,... No channel waits more than N_CH-1 transfers.
- Producers may deassert in_valid without a transfer. The arbiter re-evaluates every cycle; no grant is latched.
- Reset mid-operation: any held output word is discarded and out_valid=0 the next cycle. No partial state survives.
- in_ready never depends combinationally on in_data. in_ready does depend on out_ready and in_valid.

Optional Feature:
- Macro: RR_MUX_FIXED_PRIO_EN.
- Defined: arbitration is fixed priority. The lowest-index valid channel always wins, and rr_ptr is neither implemented nor updated. All other handshake and timing rules are unchanged.
- Undefined (default): round-robin exactly as described in Behaviour.

Test Plan:
- Reset: drive rst_n=0 for 2 cycles with all in_valid=1 -> out_valid=0, out_data=0, out_ch=0, in_ready=0000. First grant after release goes to ch0.
- Rotation: N_CH=4, DATA_W=8, in_data ch0..3 = 8'hA0,8'hA1,8'hA2,8'hA3, all valid, out_ready=1 for 8 cycles -> out_ch sequence 0,1,2,3,0,1,2,3 with matching data, out_valid continuously 1 from cycle 1.
- Skip/wrap: rr_ptr=3, only ch1 and ch3 valid -> ch3 granted, then ch1 (wrap past 0), then ch3 again.
- Back-pressure: out_valid=1 with 8'hA2, out_ready=0 for 3 cycles, ch0 valid -> out_data stays 8'hA2, out_ch=2, in_ready=0000. On out_ready=1, ch0 is accepted in the same cycle and out_data=8'hA0 next cycle.
- Idle drain: single word 8'h5C on ch2, then all in_valid=0, out_ready=1 -> out_valid is 1 for exactly one cycle then 0. out_data holds 8'h5C.
- Macro build with RR_MUX_FIXED_PRIO_EN: all channels valid, out_ready=1 -> out_ch=0 every cycle. Drop ch0 valid -> out_ch=1.
